spi_baud_rate_gen: RTL and testbench
====================================

Name: spi_baud_rate_gen

Overview:
Upstream timing stage of the SPI master. It derives the serial clock (sclk) from PCLK using the programmed prescaler/rate fields. It generates single-cycle strobes that the shift core consumes:
- flag_low / flag_high: receive-sample strobes.
- flags_low / flags_high: transmit-shift strobes.
It also drives the pad-level sclk with the correct CPOL idle level.

Parameters:
DIV_W, 12, width of baud_rate_divisor (max divisor 2048 needs 12 bits)

Ports:
PCLK  in  1  system clock; all state on posedge
PRESETn  in  1  asynchronous, active-low reset
spi_mode  in  2  00 run, 01 wait, 10/11 stop
spiswai  in  1  1 = stop SPI clock in wait mode
sppr  in  3  prescaler select
spr  in  3  rate select
cpol  in  1  clock polarity (sclk idle level)
cpha  in  1  clock phase (passed through for strobe qualification only)
ss  in  1  slave select, active-low; low = transfer in progress
sclk  out  1  serial clock to pad
baud_rate_divisor  out  DIV_W  effective divisor in PCLK cycles per sclk period
flag_low  out  1  receive strobe, sclk-low half ending
flag_high  out  1  receive strobe, sclk-high half ending
flags_low  out  1  transmit strobe, one cycle before sclk rises
flags_high  out  1  transmit strobe, one cycle before sclk falls

Behaviour:
- Reset (PRESETn low, async) clears everything to 0: sclk, count, active, flags, baud_rate_divisor.
- Divisor:
  - divisor = (sppr+1) << (spr+1); range 2..2048.
  - half = divisor>>1, giving a range of 1..1024.
  - All arithmetic is unsigned; there is no overflow at DIV_W=12.
- Divisor register:
  - Updated every cycle while active=0.
  - Frozen while active=1, so sppr/spr changes mid-transfer are ignored until the transfer ends.
  - Its output is the registered value.
- Enable:
  - en = !ss & (spi_mode==00 | (spi_mode==01 & !spiswai)).
  - active <= en each cycle.
- Idle (active=0):
  - count <= 0; sclk <= cpol.
  - All four strobes held 0.
  - The cpol value is tracked, so a cpol change while idle reaches sclk after 1 cycle.
- Run (active=1):
  - If count == half-1: count <= 0 and sclk <= ~sclk.
  - Otherwise count <= count+1.
  - First sclk edge occurs half cycles after active rises.
- Receive strobes (decoded from registered count/sclk, gated by active):
  - flag_high = active & sclk & (count==half-1).
  - flag_low = active & !sclk & (count==half-1).
  - Each coincides with the PCLK edge on which sclk toggles.
- Transmit strobes:
  - flags_high = active & sclk & (count==half-2).
  - flags_low = active & !sclk & (count==half-2).
  - This is one cycle before the matching receive strobe.
  - Boundary: when half==1, flags_* is asserted together with flag_* (count==0).
- Per sclk half-period there is exactly one flag_* and one flags_* pulse. No strobe is ever asserted while active=0.
- cpha does not alter timing. The consumer selects high/low strobes using cpha^cpol.
- Abort and mode changes:
  - ss rising mid-period: active drops next cycle; count resets and sclk returns to cpol. There is no partial-period completion.
  - Entering stop, or wait with spiswai=1, mid-transfer behaves the same as ss rising.
  - Re-entering run restarts from count=0 at the cpol level.
- Reset mid-transfer: immediate async clear. After release, sclk reaches cpol on the first clock.

Decomposition:
- Shared package spi_pkg holds:
  - Mode constants: SPI_RUN=2'b00, SPI_WAIT=2'b01, SPI_STOP=2'b10.
  - DIV_W.
  - Function spi_divisor(sppr,spr) returning a DIV_W-bit value, shared with the APB register block for readback.
- No sub-module: one counter, one toggle register, strobe decode.

Test Plan:
- sppr=0, spr=0, cpol=0, ss low, run:
  - baud_rate_divisor=2; sclk toggles every PCLK cycle, 0→1 first.
  - flag_* and flags_* both pulse on every cycle, alternating low/high.
- sppr=2, spr=1, cpol=1:
  - divisor=12; sclk idles 1, first falls 6 cycles after active.
  - flags_high at count 4, flag_high at count 5; 16 strobes of each kind over 8 sclk periods.
- sppr=7, spr=7:
  - baud_rate_divisor=2048 (12'h800); sclk half-period = 1024 PCLK.
- Divisor freeze: start with divisor 12, change spr to 3 mid-transfer.
  - Half-period stays 6 until ss high.
  - Next transfer uses divisor 48.
- Mode/abort checks:
  - Wait mode: spiswai=1 holds sclk=cpol with no strobes; spiswai=0 runs normally.
  - ss high mid half-period: sclk returns to cpol within 2 cycles and strobes stop.
- PRESETn pulsed low mid-transfer:
  - All outputs 0 immediately.
  - After release with ss low, the sequence restarts from count 0 with a correct first-edge delay.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, divisor width and the divisor helper
// used by both the baud generator and the APB register readback path.
package spi_pkg;

  localparam int DIV_W = 12;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  // Effective divisor in PCLK cycles per sclk period: (sppr+1) << (spr+1).
  // The shift amount is widened to 4 bits so spr=7 shifts by 8, not by 0.
  function automatic logic [DIV_W-1:0] spi_divisor(input logic [2:0] sppr,
                                                   input logic [2:0] spr);
    logic [DIV_W-1:0] base;
    logic [3:0]       sh;
    base = DIV_W'(sppr) + DIV_W'(1);
    sh   = {1'b0, spr} + 4'd1;
    return base << sh;
  endfunction

endpackage

// File: rtl/spi_baud_rate_gen.sv
// SPI master baud generator: divides PCLK down to sclk and emits the
// single-cycle receive (flag_*) and transmit (flags_*) strobes that drive
// the shift core. sclk idles at cpol whenever no transfer is active.
module spi_baud_rate_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = spi_pkg::DIV_W
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [1:0]       spi_mode,
  input  logic             spiswai,
  input  logic [2:0]       sppr,
  input  logic [2:0]       spr,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             ss,
  output logic             sclk,
  output logic [DIV_W-1:0] baud_rate_divisor,
  output logic             flag_low,
  output logic             flag_high,
  output logic             flags_low,
  output logic             flags_high
);

  logic             en;
  logic             active;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] half_m1;
  logic [DIV_W-1:0] half_m2;
  logic             rx_hit;
  logic             tx_hit;

  // cpha only selects which strobe pair the consumer uses; timing ignores it
  logic cpha_unused;
  assign cpha_unused = cpha;

  // Transfer enable: slave selected and clock allowed by the current mode
  always_comb begin
    en = !ss && ((spi_mode == SPI_RUN) || ((spi_mode == SPI_WAIT) && !spiswai));
  end

  assign half    = baud_rate_divisor >> 1;
  assign half_m1 = half - DIV_W'(1);
  assign half_m2 = half - DIV_W'(2);

  // Edge and pre-edge decode; with half==1 every cycle is both, so the
  // transmit strobe falls on count 0 alongside the receive strobe.
  always_comb begin
    rx_hit = (count == half_m1);
    tx_hit = (half == DIV_W'(1)) ? (count == '0) : (count == half_m2);
  end

  // Divisor tracks sppr/spr while idle and is frozen for the whole transfer
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      baud_rate_divisor <= '0;
    end else if (!active) begin
      baud_rate_divisor <= DIV_W'(spi_divisor(sppr, spr));
    end
  end

  // Active flag, half-period counter and sclk toggle register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      active <= 1'b0;
      count  <= '0;
      sclk   <= 1'b0;
    end else begin
      active <= en;
      if (!active) begin
        count <= '0;
        sclk  <= cpol;
      end else if (rx_hit) begin
        count <= '0;
        sclk  <= ~sclk;
      end else begin
        count <= count + DIV_W'(1);
      end
    end
  end

  // Strobes decoded from registered state only, so they are glitch-free
  // relative to the inputs and forced low outside a transfer.
  always_comb begin
    flag_high  = active &  sclk & rx_hit;
    flag_low   = active & !sclk & rx_hit;
    flags_high = active &  sclk & tx_hit;
    flags_low  = active & !sclk & tx_hit;
  end

endmodule

// File: tb/tb_spi_baud_rate_gen.sv
// Scoreboard bench for spi_baud_rate_gen: stimulus pushes the expected strobe
// events of each transfer, a negedge monitor pops one per observed strobe.
module tb_spi_baud_rate_gen;
  import spi_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  spi_mode;
  logic        spiswai;
  logic [2:0]  sppr;
  logic [2:0]  spr;
  logic        cpol;
  logic        cpha;
  logic        ss;
  logic        sclk;
  logic [11:0] baud_rate_divisor;
  logic        flag_low, flag_high, flags_low, flags_high;

  spi_baud_rate_gen #(.DIV_W(12)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .spi_mode(spi_mode), .spiswai(spiswai),
    .sppr(sppr), .spr(spr), .cpol(cpol), .cpha(cpha), .ss(ss), .sclk(sclk),
    .baud_rate_divisor(baud_rate_divisor), .flag_low(flag_low),
    .flag_high(flag_high), .flags_low(flags_low), .flags_high(flags_high)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // st = {flag_low, flag_high, flags_low, flags_high}
  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic       sclk;
  } ev_t;

  ev_t q[$];
  int  nchk  = 0;
  int  nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe seen must match the next expected event
  always @(negedge PCLK) begin
    logic [3:0] st;
    ev_t        e;
    st = {flag_low, flag_high, flags_low, flags_high};
    if (st != 4'b0000) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 32'(st), 32'd0);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_kind", 32'(st), 32'(e.st));
        chk("strobe_sclk", 32'(sclk), 32'(e.sclk));
      end
    end
  end

  // Expected strobes for n half-periods when active rises on posedge c+1:
  // half-period p spans cycles c+1+p*h .. c+p*h+h, transmit strobe on its
  // second-to-last cycle, receive strobe on its last.
  task automatic push_events(input int c, input int h, input logic cp, input int n);
    ev_t  e;
    logic s;
    for (int p = 0; p < n; p++) begin
      s = cp ^ p[0];
      if (h == 1) begin
        e.cyc = c + 1 + p; e.st = s ? 4'b0101 : 4'b1010; e.sclk = s; q.push_back(e);
      end else begin
        e.cyc = c + p*h + h - 1; e.st = s ? 4'b0001 : 4'b0010; e.sclk = s; q.push_back(e);
        e.cyc = c + p*h + h;     e.st = s ? 4'b0100 : 4'b1000; e.sclk = s; q.push_back(e);
      end
    end
  endtask

  // Land just after the posedge that makes cyc == n
  task automatic go_to(input int n);
    repeat (n - cyc) @(posedge PCLK);
    #1;
  endtask

  // Land on the negedge during which cyc == n
  task automatic at_neg(input int n);
    repeat (n - cyc) @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic start_xfer(input int h, input logic cp, input int n, output int c);
    c = cyc;
    push_events(c, h, cp, n);
    ss      = 1'b0;
    spiswai = 1'b0;
  endtask

  task automatic end_xfer(input int c, input int h, input int n, input logic cp);
    go_to(c + n*h);
    ss = 1'b1;
    go_to(cyc + 3);
    chk("idle_sclk_after_xfer", 32'(sclk), 32'(cp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    PRESETn = 1'b0; ss = 1'b1; spi_mode = SPI_RUN; spiswai = 1'b0;
    sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0;
    #12;
    chk("reset_sclk", 32'(sclk), 32'd0);
    chk("reset_div", 32'(baud_rate_divisor), 32'd0);
    chk("reset_strobes", 32'({flag_low, flag_high, flags_low, flags_high}), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // Divisor 2: toggles every cycle, both strobe pairs each cycle
    go_to(cyc + 2);
    chk("div_2", 32'(baud_rate_divisor), 32'd2);
    chk("idle_sclk_cpol0", 32'(sclk), 32'd0);
    start_xfer(1, 1'b0, 8, c);
    at_neg(c + 1); chk("d2_sclk_first", 32'(sclk), 32'd0);
    at_neg(c + 2); chk("d2_sclk_second", 32'(sclk), 32'd1);
    end_xfer(c, 1, 8, 1'b0);

    // Divisor 12, cpol=1: first fall 6 cycles after active, 8 periods
    sppr = 3'd2; spr = 3'd1; cpol = 1'b1;
    go_to(cyc + 2);
    chk("div_12", 32'(baud_rate_divisor), 32'd12);
    chk("idle_sclk_cpol1", 32'(sclk), 32'd1);
    start_xfer(6, 1'b1, 16, c);
    at_neg(c + 6); chk("d12_sclk_before_fall", 32'(sclk), 32'd1);
    at_neg(c + 7); chk("d12_sclk_after_fall", 32'(sclk), 32'd0);
    end_xfer(c, 6, 16, 1'b1);

    // Maximum divisor 2048
    sppr = 3'd7; spr = 3'd7; cpol = 1'b0;
    go_to(cyc + 2);
    chk("div_2048", 32'(baud_rate_divisor), 32'h800);
    start_xfer(1024, 1'b0, 2, c);
    at_neg(c + 1024); chk("d2048_sclk_before_rise", 32'(sclk), 32'd0);
    at_neg(c + 1025); chk("d2048_sclk_after_rise", 32'(sclk), 32'd1);
    end_xfer(c, 1024, 2, 1'b0);

    // Divisor frozen during a transfer, new value taken afterwards
    sppr = 3'd2; spr = 3'd1; cpol = 1'b0;
    go_to(cyc + 2);
    start_xfer(6, 1'b0, 4, c);
    go_to(c + 3);
    spr = 3'd3;
    go_to(c + 10);
    chk("div_frozen", 32'(baud_rate_divisor), 32'd12);
    end_xfer(c, 6, 4, 1'b0);
    chk("div_48", 32'(baud_rate_divisor), 32'd48);
    start_xfer(24, 1'b0, 2, c);
    end_xfer(c, 24, 2, 1'b0);

    // Wait mode: spiswai=1 holds sclk at cpol, spiswai=0 runs (divisor 4)
    sppr = 3'd1; spr = 3'd0; cpol = 1'b1;
    spi_mode = SPI_WAIT; spiswai = 1'b1; ss = 1'b0;
    go_to(cyc + 20);
    chk("wait_hold_sclk", 32'(sclk), 32'd1);
    chk("div_4", 32'(baud_rate_divisor), 32'd4);
    start_xfer(2, 1'b1, 4, c);
    end_xfer(c, 2, 4, 1'b1);

    // Stop mode: selected slave but no clock
    spi_mode = SPI_STOP; ss = 1'b0;
    go_to(cyc + 10);
    chk("stop_hold_sclk", 32'(sclk), 32'd1);
    ss = 1'b1; spi_mode = SPI_RUN;

    // Abort by ss mid half-period (sclk high, count 1)
    sppr = 3'd2; spr = 3'd1; cpol = 1'b0;
    go_to(cyc + 2);
    start_xfer(6, 1'b0, 1, c);
    go_to(c + 8);
    ss = 1'b1;
    at_neg(c + 10); chk("abort_sclk_idle", 32'(sclk), 32'd0);
    go_to(cyc + 4);
    chk("abort_sclk_stays", 32'(sclk), 32'd0);

    // Reset during a transfer, then restart with ss still low
    cpol = 1'b1;
    go_to(cyc + 2);
    start_xfer(6, 1'b1, 0, c);
    go_to(c + 4);
    PRESETn = 1'b0;
    #1;
    chk("mid_reset_sclk", 32'(sclk), 32'd0);
    chk("mid_reset_div", 32'(baud_rate_divisor), 32'd0);
    chk("mid_reset_strobes", 32'({flag_low, flag_high, flags_low, flags_high}), 32'd0);
    go_to(cyc + 2);
    PRESETn = 1'b1;
    c = cyc;
    push_events(c, 6, 1'b1, 2);
    at_neg(c + 1); chk("post_reset_sclk_cpol", 32'(sclk), 32'd1);
    at_neg(c + 6); chk("post_reset_before_fall", 32'(sclk), 32'd1);
    at_neg(c + 7); chk("post_reset_after_fall", 32'(sclk), 32'd0);
    end_xfer(c, 6, 2, 1'b1);

    go_to(cyc + 2);
    chk("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
